mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one of two cache controllers ownership of a shared memory port.
// Reads in flight are tracked by owner and delivered MEM_LAT cycles after acceptance.
module mem_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    input  logic        d_req,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        i_gnt,
    output logic        d_gnt,
    output logic [15:0] i_rdata,
    output logic [15:0] d_rdata,
    output logic        i_valid,
    output logic        d_valid,
    output logic        i_stall,
    output logic        d_stall,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_stall,
    output logic        err
);
    // One-hot so that corrupted encodings are detectable.
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        GNT_I = 4'b0010,
        GNT_D = 4'b0100,
        DRAIN = 4'b1000
    } state_t;

    state_t state, state_n;
    logic last_d;
    logic [MEM_LAT-1:0] pv, pt, pv_n, pt_n;
    logic own_i, own_d, acc, illegal;

    assign own_i = (state == GNT_I) && i_req;
    assign own_d = (state == GNT_D) && d_req;

    assign mem_rd    = own_i ? i_rd    : own_d ? d_rd    : 1'b0;
    assign mem_wr    = own_i ? i_wr    : own_d ? d_wr    : 1'b0;
    assign mem_addr  = own_i ? i_addr  : own_d ? d_addr  : 16'h0;
    assign mem_wdata = own_i ? i_wdata : own_d ? d_wdata : 16'h0;

    assign i_stall = own_i & (i_rd | i_wr) & mem_stall;
    assign d_stall = own_d & (d_rd | d_wr) & mem_stall;

    assign acc  = mem_rd & ~mem_stall;
    // pv marks occupied slots, pt tags each slot: 1 = data side.
    assign pv_n = (pv << 1) | MEM_LAT'(acc);
    assign pt_n = (pt << 1) | MEM_LAT'(own_d);

    assign i_gnt   = state == GNT_I;
    assign d_gnt   = state == GNT_D;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    assign i_valid = pv[MEM_LAT-1] & ~pt[MEM_LAT-1];
    assign d_valid = pv[MEM_LAT-1] &  pt[MEM_LAT-1];
    assign err     = (mem_rd & mem_wr) | illegal;

    always_comb begin
        state_n = IDLE;
        illegal = 1'b0;
        case (state)
            IDLE:    state_n = (d_req && (!i_req || !last_d)) ? GNT_D : i_req ? GNT_I : IDLE;
            GNT_I:   state_n = i_req ? GNT_I : (|pv ? DRAIN : IDLE);
            GNT_D:   state_n = d_req ? GNT_D : (|pv ? DRAIN : IDLE);
            DRAIN:   state_n = |pv_n ? DRAIN : IDLE;
            default: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            last_d <= 1'b0;
            pv     <= '0;
            pt     <= '0;
        end else begin
            state <= state_n;
            pv    <= pv_n;
            pt    <= pt_n;
            if (state == IDLE && state_n != IDLE)
                last_d <= state_n == GNT_D;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a transaction-level model.
// The model tracks the owner and a queue of outstanding reads with their due cycles.
module tb_mem_arbiter;
    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 0, i_rd = 0, i_wr = 0, d_req = 0, d_rd = 0, d_wr = 0;
    logic [15:0] i_addr = 0, i_wdata = 0, d_addr = 0, d_wdata = 0;
    logic        i_gnt, d_gnt, i_valid, d_valid, i_stall, d_stall;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        mem_rd, mem_wr, err;
    logic [15:0] mem_rdata = 0;
    logic        mem_stall = 0;

    mem_arbiter #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_rd(i_rd), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
        .d_req(d_req), .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .i_gnt(i_gnt), .d_gnt(d_gnt), .i_rdata(i_rdata), .d_rdata(d_rdata),
        .i_valid(i_valid), .d_valid(d_valid), .i_stall(i_stall), .d_stall(d_stall),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        bit is_d;
    } rd_t;

    rd_t q[$];
    int  owner;   // 0 none, 1 I, 2 D, 3 draining
    bit  last_d;
    int  cyc;
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        owner  = 0;
        last_d = 0;
    endfunction

    // Compare every output against the model for the current cycle.
    task automatic cyc_chk();
        bit fi, fd, vi, vd;
        @(negedge clk);
        fi = owner == 1 && i_req;
        fd = owner == 2 && d_req;
        vi = q.size() > 0 && q[0].due == cyc && !q[0].is_d;
        vd = q.size() > 0 && q[0].due == cyc &&  q[0].is_d;
        chk("i_gnt", i_gnt, owner == 1);
        chk("d_gnt", d_gnt, owner == 2);
        chk("mem_rd", mem_rd, fi ? i_rd : fd ? d_rd : 0);
        chk("mem_wr", mem_wr, fi ? i_wr : fd ? d_wr : 0);
        chk("mem_addr", mem_addr, fi ? i_addr : fd ? d_addr : 0);
        chk("mem_wdata", mem_wdata, fi ? i_wdata : fd ? d_wdata : 0);
        chk("i_stall", i_stall, fi && (i_rd || i_wr) && mem_stall);
        chk("d_stall", d_stall, fd && (d_rd || d_wr) && mem_stall);
        chk("i_valid", i_valid, vi);
        chk("d_valid", d_valid, vd);
        chk("err", err, (fi && i_rd && i_wr) || (fd && d_rd && d_wr));
        chk("i_rdata", i_rdata, mem_rdata);
        chk("d_rdata", d_rdata, mem_rdata);
    endtask

    task automatic cyc_adv();
        bit fi, fd, mr, occ;
        rd_t e;
        fi  = owner == 1 && i_req;
        fd  = owner == 2 && d_req;
        mr  = fi ? i_rd : fd ? d_rd : 0;
        occ = q.size() > 0;
        if (mr && !mem_stall) begin
            e.due  = cyc + MEM_LAT;
            e.is_d = fd;
            q.push_back(e);
        end
        while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
        case (owner)
            0: if (d_req && (!i_req || !last_d)) begin owner = 2; last_d = 1; end
               else if (i_req) begin owner = 1; last_d = 0; end
            1: if (!i_req) owner = occ ? 3 : 0;
            2: if (!d_req) owner = occ ? 3 : 0;
            default: if (q.size() == 0) owner = 0;
        endcase
        @(posedge clk);
        #1;
        cyc++;
        mem_rdata = 16'($urandom);
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            cyc_chk();
            cyc_adv();
        end
    endtask

    // Called just after a rising edge; checks outputs are forced low while rst is high.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_i_gnt", i_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_valid", {i_valid, d_valid}, 0);
        chk("rst_stall", {i_stall, d_stall}, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        model_reset();
    endtask

    task automatic idle_inputs();
        {i_req, i_rd, i_wr, d_req, d_rd, d_wr, mem_stall} = '0;
    endtask

    initial begin
        int n;
        model_reset();
        cyc = 0;
        @(posedge clk);
        #1;
        do_reset();
        step(2);

        // Single data read: grant, forward, then valid two cycles later.
        d_req = 1;
        step();
        d_rd = 1; d_addr = 16'h1230;
        cyc_chk();
        chk("r029_gnt", d_gnt, 1);
        chk("r029_rd", mem_rd, 1);
        chk("r029_addr", mem_addr, 16'h1230);
        cyc_adv();
        d_rd = 0;
        step();
        mem_rdata = 16'hBEEF;
        cyc_chk();
        chk("r029_valid", d_valid, 1);
        chk("r029_rdata", d_rdata, 16'hBEEF);
        chk("r029_ivalid", i_valid, 0);
        cyc_adv();
        d_req = 0;
        step(3);

        // Tie-break and alternation.
        do_reset();
        i_req = 1; d_req = 1;
        step();
        cyc_chk();
        chk("r030_d_first", d_gnt, 1);
        cyc_adv();
        d_req = 0;
        step();
        cyc_chk();
        chk("r030_idle_gap", {i_gnt, d_gnt}, 0);
        cyc_adv();
        cyc_chk();
        chk("r030_i_next", i_gnt, 1);
        cyc_adv();
        d_req = 1;
        step();
        i_req = 0;
        step();
        i_req = 1;
        step();
        cyc_chk();
        chk("r030_alt_d", d_gnt, 1);
        cyc_adv();

        // Burst of four reads then release; I waits for drain plus an idle cycle.
        do_reset();
        idle_inputs();
        i_req = 1; d_req = 1;
        step();
        d_rd = 1;
        for (int k = 0; k < 4; k++) begin
            d_addr = 16'h0100 + 16'(k);
            step();
        end
        d_rd = 0; d_req = 0;
        n = 0;
        while (n < 20) begin
            cyc_chk();
            if (i_gnt) break;
            cyc_adv();
            n++;
        end
        chk("r031_gap", 16'(n), 16'd3);
        cyc_adv();
        i_req = 0;
        step(3);

        // Non-owner strobes are ignored.
        do_reset();
        idle_inputs();
        d_req = 1;
        step();
        d_rd = 1; d_addr = 16'h5555; i_rd = 1; i_addr = 16'h0040;
        cyc_chk();
        chk("r032_addr", mem_addr, 16'h5555);
        chk("r032_istall", i_stall, 0);
        cyc_adv();
        d_rd = 0;
        step(4);

        // Stalled read: two refused cycles, then exactly one valid.
        d_rd = 1; mem_stall = 1;
        cyc_chk();
        chk("r033_stall", d_stall, 1);
        cyc_adv();
        step();
        mem_stall = 0;
        step();
        d_rd = 0;
        step(4);

        // Simultaneous rd/wr flags err; reset mid-burst drops everything.
        d_rd = 1; d_wr = 1;
        cyc_chk();
        chk("r034_err", err, 1);
        cyc_adv();
        d_wr = 0;
        step();
        do_reset();
        d_rd = 0; d_req = 0;
        step(5);

        // Randomised traffic.
        idle_inputs();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(7) == 0) i_req = ~i_req;
            if ($urandom_range(7) == 0) d_req = ~d_req;
            i_rd = $urandom_range(2) == 0;
            d_rd = $urandom_range(2) == 0;
            i_wr = $urandom_range(5) == 0;
            d_wr = $urandom_range(5) == 0;
            i_addr = 16'($urandom); d_addr = 16'($urandom);
            i_wdata = 16'($urandom); d_wdata = 16'($urandom);
            mem_stall = $urandom_range(3) == 0;
            if ($urandom_range(99) == 0) do_reset();
            step();
        end
        idle_inputs();
        step(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
